// File: rtl/adc_front_sync_if.sv
// Signal bundle between the ADC/comparator front end and its consumer.
// The master side drives the raw inputs; the slave side is the front end.
interface adc_front_sync_if #(
  parameter int PERIOD_W = 20
);
  logic                en;
  logic [11:0]         adc_data_in;
  logic                comp_in;
  logic                adc_clk;
  logic [11:0]         sync_adc_data;
  logic                sync_signal_in;
  logic                stable;
  logic [PERIOD_W-1:0] period;

  modport master (
    output en, adc_data_in, comp_in,
    input  adc_clk, sync_adc_data, sync_signal_in, stable, period
  );

  modport slave (
    input  en, adc_data_in, comp_in,
    output adc_clk, sync_adc_data, sync_signal_in, stable, period
  );
endinterface

// File: rtl/adc_front_sync.sv
// ADC front end: divided sample clock, ADC word capture, comparator
// synchroniser + glitch filter, and period measurement with lock detection.
module adc_front_sync #(
  parameter int DIV         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int PERIOD_W    = 20,
  parameter int TOL         = 8,
  parameter int STABLE_CNT  = 4,
  parameter int TIMEOUT     = 1000000
) (
  input  logic            clk,
  input  logic            rst_n,
  adc_front_sync_if.slave bus
);
  localparam int CNT_W  = $clog2(DIV);
  localparam int FCNT_W = $clog2(FILT_LEN + 1);
  localparam int MCNT_W = $clog2(STABLE_CNT + 1);
  localparam int PW1    = PERIOD_W + 1;

  localparam logic [CNT_W-1:0]    DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]    DIV_HALF   = CNT_W'(DIV / 2);
  localparam logic [FCNT_W-1:0]   FILT_LAST  = FCNT_W'(FILT_LEN - 1);
  localparam logic [MCNT_W-1:0]   MATCH_DONE = MCNT_W'(STABLE_CNT);
  localparam logic [PERIOD_W-1:0] TIMEOUT_V  = PERIOD_W'(TIMEOUT);
  localparam logic [PW1-1:0]      TOL_V      = PW1'(TOL);

  typedef enum logic [1:0] {NO_SIGNAL, MEASURE, ACQUIRE, LOCKED} state_t;

  logic [CNT_W-1:0]       div_cnt_r;
  logic                   adc_clk_r;
  logic [11:0]            adc_in_r;
  logic [11:0]            adc_data_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   filt_r;
  logic [FCNT_W-1:0]      filt_cnt_r;
  logic [PERIOD_W-1:0]    per_cnt_r;
  logic [PERIOD_W-1:0]    ref_r;
  logic [PERIOD_W-1:0]    period_r;
  logic [MCNT_W-1:0]      match_r;
  state_t                 state_r;
  logic                   stable_r;

  logic                   sync_bit_s;
  logic                   filt_diff_s;
  logic                   filt_toggle_s;
  logic                   rise_s;
  logic signed [PW1-1:0]  delta_s;
  logic [PW1-1:0]         abs_s;
  logic                   match_s;
  logic                   timeout_s;
  logic [MCNT_W-1:0]      match_inc_s;

  // Filter decode: a toggle happens on the FILT_LEN-th consecutive differing sample.
  always_comb begin
    sync_bit_s    = sync_r[SYNC_STAGES-1];
    filt_diff_s   = (sync_bit_s != filt_r);
    filt_toggle_s = filt_diff_s && (filt_cnt_r == FILT_LAST);
    rise_s        = filt_toggle_s && !filt_r;
  end

  // Period comparison done one bit wider and signed so the difference never wraps.
  always_comb begin
    delta_s     = $signed({1'b0, per_cnt_r}) - $signed({1'b0, ref_r});
    abs_s       = delta_s[PERIOD_W] ? PW1'(-delta_s) : PW1'(delta_s);
    match_s     = (abs_s <= TOL_V);
    timeout_s   = (per_cnt_r == TIMEOUT_V);
    match_inc_s = match_r + MCNT_W'(1);
  end

  // Sample-clock divider; adc_clk is high for the first half of each count cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {CNT_W{1'b0}};
      adc_clk_r <= 1'b0;
    end else if (!bus.en) begin
      div_cnt_r <= {CNT_W{1'b0}};
      adc_clk_r <= 1'b0;
    end else begin
      div_cnt_r <= (div_cnt_r == DIV_LAST) ? {CNT_W{1'b0}} : div_cnt_r + CNT_W'(1);
      adc_clk_r <= (div_cnt_r < DIV_HALF);
    end
  end

  // ADC capture: one metastability stage, then transfer on the adc_clk falling cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_in_r   <= 12'h000;
      adc_data_r <= 12'h000;
    end else if (!bus.en) begin
      adc_in_r   <= 12'h000;
      adc_data_r <= 12'h000;
    end else begin
      adc_in_r <= bus.adc_data_in;
      if (div_cnt_r == DIV_HALF) begin
        adc_data_r <= adc_in_r;
      end
    end
  end

  // Comparator synchroniser and glitch filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r     <= {SYNC_STAGES{1'b0}};
      filt_r     <= 1'b0;
      filt_cnt_r <= {FCNT_W{1'b0}};
    end else if (!bus.en) begin
      sync_r     <= {SYNC_STAGES{1'b0}};
      filt_r     <= 1'b0;
      filt_cnt_r <= {FCNT_W{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.comp_in};
      if (filt_toggle_s) begin
        filt_r     <= ~filt_r;
        filt_cnt_r <= {FCNT_W{1'b0}};
      end else if (filt_diff_s) begin
        filt_cnt_r <= filt_cnt_r + FCNT_W'(1);
      end else begin
        filt_cnt_r <= {FCNT_W{1'b0}};
      end
    end
  end

  // Period counter: restarts at 1 on each filtered rise so it reads the edge distance; saturates at TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_r <= {PERIOD_W{1'b0}};
    end else if (!bus.en) begin
      per_cnt_r <= {PERIOD_W{1'b0}};
    end else if (rise_s) begin
      per_cnt_r <= PERIOD_W'(1);
    end else if (per_cnt_r < TIMEOUT_V) begin
      per_cnt_r <= per_cnt_r + PERIOD_W'(1);
    end else begin
      per_cnt_r <= per_cnt_r;
    end
  end

  // Lock FSM with registered period and stable outputs; an edge takes priority over timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= NO_SIGNAL;
      ref_r    <= {PERIOD_W{1'b0}};
      period_r <= {PERIOD_W{1'b0}};
      match_r  <= {MCNT_W{1'b0}};
      stable_r <= 1'b0;
    end else if (!bus.en) begin
      state_r  <= NO_SIGNAL;
      ref_r    <= {PERIOD_W{1'b0}};
      period_r <= {PERIOD_W{1'b0}};
      match_r  <= {MCNT_W{1'b0}};
      stable_r <= 1'b0;
    end else begin
      stable_r <= (state_r == LOCKED);
      case (state_r)
        NO_SIGNAL: begin
          if (rise_s) begin
            state_r <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise_s) begin
            ref_r    <= per_cnt_r;
            period_r <= per_cnt_r;
            match_r  <= {MCNT_W{1'b0}};
            state_r  <= ACQUIRE;
          end else if (timeout_s) begin
            period_r <= {PERIOD_W{1'b0}};
            match_r  <= {MCNT_W{1'b0}};
            state_r  <= NO_SIGNAL;
          end
        end
        ACQUIRE: begin
          if (rise_s) begin
            ref_r    <= per_cnt_r;
            period_r <= per_cnt_r;
            if (match_s) begin
              match_r <= match_inc_s;
              if (match_inc_s == MATCH_DONE) begin
                state_r <= LOCKED;
              end
            end else begin
              match_r <= {MCNT_W{1'b0}};
            end
          end else if (timeout_s) begin
            period_r <= {PERIOD_W{1'b0}};
            match_r  <= {MCNT_W{1'b0}};
            state_r  <= NO_SIGNAL;
          end
        end
        LOCKED: begin
          if (rise_s) begin
            ref_r    <= per_cnt_r;
            period_r <= per_cnt_r;
            if (!match_s) begin
              match_r <= {MCNT_W{1'b0}};
              state_r <= ACQUIRE;
            end
          end else if (timeout_s) begin
            period_r <= {PERIOD_W{1'b0}};
            match_r  <= {MCNT_W{1'b0}};
            state_r  <= NO_SIGNAL;
          end
        end
        default: begin
          state_r <= NO_SIGNAL;
        end
      endcase
    end
  end

  assign bus.adc_clk        = adc_clk_r;
  assign bus.sync_adc_data  = adc_data_r;
  assign bus.sync_signal_in = filt_r;
  assign bus.stable         = stable_r;
  assign bus.period         = period_r;
endmodule

// File: doc/adc_front_sync.md
Name: adc_front_sync

Overview:
Upstream conditioning stage that feeds dual_buffer. It generates the divided ADC sample clock (adc_clk) and captures the asynchronous 12-bit ADC parallel bus into the clk domain. It also synchronises and de-glitches the voltage-comparator square wave. Finally, it measures the comparator period and asserts stable once the input frequency has locked. Outputs connect directly to dual_buffer's adc_clk, sync_adc_data, sync_signal_in and stable inputs.

Parameters:
DIV, 4, adc_clk division ratio; even, >=2; adc_clk period = DIV clk cycles, 50% duty.
SYNC_STAGES, 2, comparator synchroniser flop count (>=2).
FILT_LEN, 4, consecutive identical samples required before the filtered comparator output changes.
PERIOD_W, 20, width of the period counter and period output.
TOL, 8, maximum |period - reference| in clk cycles still counted as a match.
STABLE_CNT, 4, consecutive matching periods required to assert stable.
TIMEOUT, 1000000, clk cycles without a filtered rising edge before dropping to NO_SIGNAL; must be < 2^PERIOD_W.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
en  in  1  block enable; low = hold everything in reset values
adc_data_in  in  12  asynchronous ADC parallel data bus
comp_in  in  1  asynchronous comparator square wave
adc_clk  out  1  divided ADC sample clock (also drives the ADC)
sync_adc_data  out  12  captured ADC word, clk domain
sync_signal_in  out  1  synchronised, glitch-filtered comparator
stable  out  1  frequency lock indicator
period  out  PERIOD_W  last measured comparator period in clk cycles

Behaviour:
- Reset is asynchronous (rst_n low). Every output is 0: adc_clk, sync_adc_data, sync_signal_in, stable and period. Divider count, filter state, match count and FSM (NO_SIGNAL) are also cleared.
- en low is synchronous: applies the same clear as reset on every cycle. en rising: divider restarts from count 0.
- Divider:
  - cnt runs 0..DIV-1 and wraps.
  - adc_clk is registered: 1 when cnt < DIV/2, else 0.
  - First adc_clk rise occurs 1 cycle after reset release.
- ADC capture:
  - adc_data_in is registered every clk into an input register (metastability absorption).
  - The input register is transferred to sync_adc_data on the cycle adc_clk goes low (cnt == DIV/2).
  - sync_adc_data therefore holds for DIV cycles and is stable across the next adc_clk rising edge.
- Comparator path:
  - SYNC_STAGES-flop synchroniser feeds the filter.
  - Filter: sync_signal_in toggles only after FILT_LEN consecutive synchronised samples all differ from the current output.
  - Shorter pulses are discarded.
  - Total latency from an input edge to the output edge is SYNC_STAGES+FILT_LEN cycles (6 at defaults).
- Period measurement:
  - Measured distance = clk cycles between consecutive rising edges of sync_signal_in.
  - The counter saturates at TIMEOUT.
- FSM (rising edges of sync_signal_in drive all transitions):
  - NO_SIGNAL: first edge -> MEASURE; counter cleared.
  - MEASURE: next edge -> ref = measured, period = measured, match = 0 -> ACQUIRE.
  - ACQUIRE, match on edge: |measured - ref| <= TOL -> match+1. If match+1 == STABLE_CNT -> LOCKED.
  - ACQUIRE, mismatch on edge: match = 0.
  - ACQUIRE, every edge: ref = measured, period = measured.
  - LOCKED, match on edge: stay LOCKED.
  - LOCKED, mismatch on edge: -> ACQUIRE, match = 0.
  - LOCKED, every edge: ref and period update.
  - Any state except NO_SIGNAL: counter reaching TIMEOUT -> NO_SIGNAL, period = 0, match = 0.
- stable is registered (state == LOCKED).
  - Rises 1 cycle after the edge that completes STABLE_CNT matches.
  - Falls 1 cycle after a mismatching edge or timeout.
- |diff| is computed at PERIOD_W+1 bits signed; there is no wrap.
- An edge and a timeout in the same cycle: the edge wins.

Test Plan:
1. Reset and divider (DIV=4): hold rst_n low -> all outputs 0. Release -> adc_clk reads 1,1,0,0 repeating; assert rst_n mid-high -> adc_clk 0 immediately.
2. Data capture: adc_data_in=0xABC, then 0x123 driven only while adc_clk is high -> sync_adc_data=0xABC until the next adc_clk fall, then 0x123; never changes while adc_clk is high.
3. Glitch filter: 3-cycle comp_in pulse -> sync_signal_in stays 0. 5-cycle pulse -> sync_signal_in rises 6 cycles after the comp_in rise.
4. Lock: comp_in square wave, period 200 cycles -> stable rises 1 cycle after the 6th filtered rising edge; period=200.
5. Jitter/mismatch: locked, then periods 200/205/198 -> stable stays 1. Then one 220-cycle period -> stable falls next cycle, period=220. Then 4 periods of 220 -> stable returns to 1.
6. Timeout and enable (TIMEOUT=1000): stop comp_in while locked -> stable=0 and period=0 after 1000 cycles. Separately, drop en while locked -> all outputs 0 next cycle; after en returns, stable needs 6 fresh edges.
